// File: rtl/cpu_serial_frame_io.sv
// ============================================================================
// Module   : cpu_serial_frame_io
// Brief    : Deserialises a start-triggered {A,B,opcode} frame, issues it over
//            valid/ready, then serialises {result,flags} back out MSB first.
//            Optional parity in both directions: define CPU_SERIAL_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_serial_frame_io #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 5,
  parameter int FLAG_W      = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ser_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  output logic              load_valid,
  input  logic              exec_ready,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              ser_out,
  output logic              ser_out_valid,
  output logic              busy,
  output logic              frame_err
);

`ifdef CPU_SERIAL_PARITY_EN
  localparam int c_par_w = 1;
`else
  localparam int c_par_w = 0;
`endif
  localparam int c_out_len = DATA_W + FLAG_W + c_par_w;
  localparam int c_cnt_max = (c_out_len + 1 > TIMEOUT_CYC + 1) ? (c_out_len + 1) : (TIMEOUT_CYC + 1);
  localparam int CNT_W     = $clog2(c_cnt_max);

  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_op_last   = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_out_last  = CNT_W'(c_out_len - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_A    = 3'd1,
    S_LOAD_B    = 3'd2,
    S_LOAD_OP   = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_RES  = 3'd5,
    S_SHIFT_OUT = 3'd6
`ifdef CPU_SERIAL_PARITY_EN
    ,
    S_LOAD_PAR  = 3'd7
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [c_out_len-1:0]   r_sh;
  logic                   w_cnt_clr;
  logic                   w_err_set;
  logic [c_out_len-1:0]   w_cap;

`ifdef CPU_SERIAL_PARITY_EN
  logic w_par_err;
  // Even parity: XOR over every data bit plus the received parity bit must be 0.
  assign w_par_err = ^{a_out, b_out, op_out, ser_in};
  assign w_cap     = {result_in, flags_in, ^{result_in, flags_in}};
`else
  assign w_cap     = {result_in, flags_in};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (start) w_state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (r_cnt == c_data_last) begin
          w_state_nxt = S_LOAD_B;
          w_cnt_clr   = 1'b1;
        end
      end
      S_LOAD_B: begin
        if (r_cnt == c_data_last) begin
          w_state_nxt = S_LOAD_OP;
          w_cnt_clr   = 1'b1;
        end
      end
      S_LOAD_OP: begin
        if (r_cnt == c_op_last) begin
`ifdef CPU_SERIAL_PARITY_EN
          w_state_nxt = S_LOAD_PAR;
`else
          w_state_nxt = S_ISSUE;
`endif
          w_cnt_clr   = 1'b1;
        end
      end
`ifdef CPU_SERIAL_PARITY_EN
      S_LOAD_PAR: begin
        w_cnt_clr = 1'b1;
        if (w_par_err) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
`endif
      S_ISSUE: begin
        w_cnt_clr = 1'b1;
        if (exec_ready) w_state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (result_valid) begin
          w_state_nxt = S_SHIFT_OUT;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == c_to_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_clr   = 1'b1;
          w_err_set   = 1'b1;
        end
      end
      S_SHIFT_OUT: begin
        if (r_cnt == c_out_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_clr   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sh      <= '0;
      a_out     <= '0;
      b_out     <= '0;
      op_out    <= '0;
      frame_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : (r_cnt + c_cnt_one);
      case (r_state)
        S_IDLE:      if (start) frame_err <= 1'b0;
        S_LOAD_A:    a_out  <= {a_out[DATA_W-2:0], ser_in};
        S_LOAD_B:    b_out  <= {b_out[DATA_W-2:0], ser_in};
        // Shift form that also works for a single-bit opcode.
        S_LOAD_OP:   op_out <= (op_out << 1) | OP_W'(ser_in);
        S_WAIT_RES:  if (result_valid) r_sh <= w_cap;
        S_SHIFT_OUT: r_sh   <= r_sh << 1;
        default:     ;
      endcase
      if (w_err_set) frame_err <= 1'b1;
    end
  end

  assign load_valid    = (r_state == S_ISSUE);
  assign ser_out_valid = (r_state == S_SHIFT_OUT);
  assign ser_out       = (r_state == S_SHIFT_OUT) & r_sh[c_out_len-1];
  assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire
